// File: rtl/cafe_pkg.sv
// Shared coffee-machine definitions: brew stage codes, error codes and drink type width.
// Used by the brew sequencer, the main coffee FSM and the display/LED output mux.
`timescale 1ns/1ps
package cafe_pkg;

  localparam int TIPO_W = 2;

  typedef enum logic [2:0] {
    ST_OCIOSO   = 3'd0,
    ST_VERIFICA = 3'd1,
    ST_AQUECE   = 3'd2,
    ST_MOE      = 3'd3,
    ST_DISPENSA = 3'd4,
    ST_FIM      = 3'd5,
    ST_ERRO     = 3'd6
  } etapa_e;

  typedef enum logic [1:0] {
    COD_NENHUM   = 2'd0,
    COD_SEM_COPO = 2'd1,
    COD_SEM_AGUA = 2'd2,
    COD_SEM_CAFE = 2'd3
  } cod_erro_e;

  function automatic logic etapa_ocupada(input etapa_e e);
    return (e == ST_VERIFICA) || (e == ST_AQUECE) || (e == ST_MOE) ||
           (e == ST_DISPENSA) || (e == ST_FIM);
  endfunction

endpackage

// File: rtl/sequenciador_preparo_temporizador_etapa.sv
// Stage timer: loadable down-counter that steps on TICK.
// expirado flags the TICK that ends the stage (counter at 1), so a stage of N lasts N TICKs.
`timescale 1ns/1ps
module temporizador_etapa #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             carregar,
  input  logic [CNT_W-1:0] valor,
  input  logic             tick,
  output logic             expirado
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (carregar) begin
      cnt_d = valor;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expirado = tick && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sequenciador_preparo.sv
// Coffee brew sequencer: sensor check, then heat/grind/dispense stages timed in TICKs.
// Optional abort input enabled by defining SEQ_CANCELAR_EN.
`timescale 1ns/1ps
module sequenciador_preparo
  import cafe_pkg::*;
#(
  parameter int T_AQUEC      = 4,
  parameter int T_MOAGEM     = 2,
  parameter int T_DISP_BASE  = 3,
  parameter int T_DISP_EXTRA = 2,
  parameter int CNT_W        = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TICK,
  input  logic              INICIAR,
  input  logic [TIPO_W-1:0] TIPO,
  input  logic              SENSOR_COPO,
  input  logic              SENSOR_AGUA,
  input  logic              SENSOR_CAFE,
`ifdef SEQ_CANCELAR_EN
  input  logic              CANCELAR,
`endif
  output logic              AQUECER,
  output logic              MOER,
  output logic              DISPENSAR,
  output logic              OCUPADO,
  output logic              CONCLUIDO,
  output logic              ERRO,
  output logic [1:0]        COD_ERRO,
  output logic [2:0]        ETAPA
);

  if ((T_AQUEC < 1) || (T_MOAGEM < 1) || (T_DISP_BASE < 1) ||
      (T_DISP_BASE + 3 * T_DISP_EXTRA >= (1 << CNT_W))) begin : g_param_check
    $error("sequenciador_preparo: stage lengths must be >=1 and fit in CNT_W bits");
  end

  etapa_e            state_q, state_d;
  logic [TIPO_W-1:0] tipo_q, tipo_d;
  cod_erro_e         cod_q, cod_d;
  logic              carregar;
  logic [CNT_W-1:0]  valor;
  logic              expirado;
  logic              cancelar;
  logic [CNT_W-1:0]  len_disp;

`ifdef SEQ_CANCELAR_EN
  assign cancelar = CANCELAR;
`else
  assign cancelar = 1'b0;
`endif

  assign len_disp = CNT_W'(T_DISP_BASE) + CNT_W'(tipo_q) * CNT_W'(T_DISP_EXTRA);

  temporizador_etapa #(.CNT_W(CNT_W)) u_temporizador (
    .clk      (CLK),
    .rst      (RST),
    .carregar (carregar),
    .valor    (valor),
    .tick     (TICK),
    .expirado (expirado)
  );

  always_comb begin
    state_d  = state_q;
    tipo_d   = tipo_q;
    cod_d    = cod_q;
    carregar = 1'b0;
    valor    = '0;
    case (state_q)
      ST_OCIOSO: begin
        if (INICIAR) begin
          tipo_d  = TIPO;
          state_d = ST_VERIFICA;
        end
      end
      ST_VERIFICA: begin
        if (cancelar) begin
          state_d = ST_OCIOSO;
        end else if (!SENSOR_COPO) begin
          state_d = ST_ERRO;
          cod_d   = COD_SEM_COPO;
        end else if (!SENSOR_AGUA) begin
          state_d = ST_ERRO;
          cod_d   = COD_SEM_AGUA;
        end else if (!SENSOR_CAFE) begin
          state_d = ST_ERRO;
          cod_d   = COD_SEM_CAFE;
        end else begin
          state_d  = ST_AQUECE;
          carregar = 1'b1;
          valor    = CNT_W'(T_AQUEC);
        end
      end
      // Abort beats faults, faults beat the stage-ending TICK; leaving early clears the timer.
      ST_AQUECE, ST_MOE, ST_DISPENSA: begin
        if (cancelar) begin
          state_d  = ST_OCIOSO;
          carregar = 1'b1;
        end else if (!SENSOR_COPO) begin
          state_d  = ST_ERRO;
          cod_d    = COD_SEM_COPO;
          carregar = 1'b1;
        end else if (!SENSOR_AGUA && (state_q != ST_MOE)) begin
          state_d  = ST_ERRO;
          cod_d    = COD_SEM_AGUA;
          carregar = 1'b1;
        end else if (expirado) begin
          carregar = 1'b1;
          case (state_q)
            ST_AQUECE: begin
              state_d = ST_MOE;
              valor   = CNT_W'(T_MOAGEM);
            end
            ST_MOE: begin
              state_d = ST_DISPENSA;
              valor   = len_disp;
            end
            default: state_d = ST_FIM;
          endcase
        end
      end
      ST_FIM: state_d = ST_OCIOSO;
      ST_ERRO: begin
        if (INICIAR) begin
          cod_d   = COD_NENHUM;
          state_d = ST_OCIOSO;
        end
      end
      default: begin
        state_d = ST_OCIOSO;
        cod_d   = COD_NENHUM;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_OCIOSO;
      tipo_q  <= '0;
      cod_q   <= COD_NENHUM;
    end else begin
      state_q <= state_d;
      tipo_q  <= tipo_d;
      cod_q   <= cod_d;
    end
  end

  assign ETAPA     = state_q;
  assign AQUECER   = (state_q == ST_AQUECE);
  assign MOER      = (state_q == ST_MOE);
  assign DISPENSAR = (state_q == ST_DISPENSA);
  assign CONCLUIDO = (state_q == ST_FIM);
  assign ERRO      = (state_q == ST_ERRO);
  assign OCUPADO   = etapa_ocupada(state_q);
  assign COD_ERRO  = cod_q;

endmodule

// File: tb/tb_sequenciador_preparo.sv
// Bench for sequenciador_preparo: output segments (runs of a constant output vector)
// are matched against an expected-segment scoreboard; SEQ_CANCELAR_EN adds the abort case.
`timescale 1ns/1ps
module tb_sequenciador_preparo;
  import cafe_pkg::*;

  logic       CLK = 1'b0;
  logic       RST, TICK, INICIAR;
  logic [1:0] TIPO;
  logic       SENSOR_COPO, SENSOR_AGUA, SENSOR_CAFE;
  logic       AQUECER, MOER, DISPENSAR, OCUPADO, CONCLUIDO, ERRO;
  logic [1:0] COD_ERRO;
  logic [2:0] ETAPA;
`ifdef SEQ_CANCELAR_EN
  logic       CANCELAR;
`endif

  sequenciador_preparo dut (
    .CLK         (CLK),
    .RST         (RST),
    .TICK        (TICK),
    .INICIAR     (INICIAR),
    .TIPO        (TIPO),
    .SENSOR_COPO (SENSOR_COPO),
    .SENSOR_AGUA (SENSOR_AGUA),
    .SENSOR_CAFE (SENSOR_CAFE),
`ifdef SEQ_CANCELAR_EN
    .CANCELAR    (CANCELAR),
`endif
    .AQUECER     (AQUECER),
    .MOER        (MOER),
    .DISPENSAR   (DISPENSAR),
    .OCUPADO     (OCUPADO),
    .CONCLUIDO   (CONCLUIDO),
    .ERRO        (ERRO),
    .COD_ERRO    (COD_ERRO),
    .ETAPA       (ETAPA)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic [10:0] vec;
    int          cycles;
    int          ticks;
  } seg_t;

  seg_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          tick_ph  = 0;
  int          seg_idx  = 0;
  logic        mon_en   = 1'b0;
  logic        mon_started = 1'b0;
  logic [10:0] cur_vec;
  int          cur_cyc, cur_tk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [10:0] ev(input etapa_e e, input logic [1:0] cod);
    logic ocup;
    ocup = (e == ST_VERIFICA) || (e == ST_AQUECE) || (e == ST_MOE) ||
           (e == ST_DISPENSA) || (e == ST_FIM);
    return {e, e == ST_AQUECE, e == ST_MOE, e == ST_DISPENSA, ocup,
            e == ST_FIM, e == ST_ERRO, cod};
  endfunction

  task automatic push_seg(input etapa_e e, input int cyc, input int tk, input logic [1:0] cod);
    seg_t s;
    s.vec    = ev(e, cod);
    s.cycles = cyc;
    s.ticks  = tk;
    sb_q.push_back(s);
  endtask

  task automatic close_seg();
    seg_t e;
    check_eq($sformatf("seg%0d_present", seg_idx), 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq($sformatf("seg%0d_vec", seg_idx), 32'(cur_vec), 32'(e.vec));
      if (e.cycles >= 0) check_eq($sformatf("seg%0d_cycles", seg_idx), cur_cyc, e.cycles);
      if (e.ticks >= 0)  check_eq($sformatf("seg%0d_ticks", seg_idx), cur_tk, e.ticks);
    end
    seg_idx++;
  endtask

  task automatic sample_seg();
    logic [10:0] v;
    v = {ETAPA, AQUECER, MOER, DISPENSAR, OCUPADO, CONCLUIDO, ERRO, COD_ERRO};
    if (!mon_en) return;
    if (!mon_started) begin
      mon_started = 1'b1;
      cur_vec = v; cur_cyc = 1; cur_tk = int'(TICK);
    end else if (v !== cur_vec) begin
      close_seg();
      cur_vec = v; cur_cyc = 1; cur_tk = int'(TICK);
    end else begin
      cur_cyc++;
      cur_tk += int'(TICK);
    end
  endtask

  // One clock: sample outputs at the falling edge, then advance the TICK pattern after the rising edge.
  task automatic step();
    @(negedge CLK);
    sample_seg();
    @(posedge CLK);
    #1;
    tick_ph = (tick_ph + 1) % 4;
    TICK = (tick_ph == 0);
  endtask

  task automatic start_brew(input logic [1:0] t);
    TIPO = t;
    INICIAR = 1'b1;
    step();
    INICIAR = 1'b0;
  endtask

  task automatic wait_etapa(input etapa_e target, input string tag);
    int n = 0;
    while ((ETAPA !== target) && (n < 300)) begin
      step();
      n++;
    end
    check_eq(tag, 32'(ETAPA), 32'(target));
  endtask

  task automatic ack_erro();
    INICIAR = 1'b1;
    step();
    INICIAR = 1'b0;
  endtask

  typedef struct { logic copo; logic agua; logic cafe; logic [1:0] cod; } verif_t;
  verif_t vtab[4] = '{'{1'b0, 1'b1, 1'b1, 2'd1}, '{1'b1, 1'b0, 1'b0, 2'd2},
                      '{1'b1, 1'b1, 1'b0, 2'd3}, '{1'b0, 1'b0, 1'b0, 2'd1}};

  initial begin
    int n, k;
    RST = 1'b1; TICK = 1'b0; INICIAR = 1'b0; TIPO = 2'd0;
    SENSOR_COPO = 1'b1; SENSOR_AGUA = 1'b1; SENSOR_CAFE = 1'b1;
`ifdef SEQ_CANCELAR_EN
    CANCELAR = 1'b0;
`endif
    repeat (3) step();
    check_eq("rst_vec", 32'({ETAPA, AQUECER, MOER, DISPENSAR, OCUPADO, CONCLUIDO, ERRO, COD_ERRO}),
             32'(ev(ST_OCIOSO, 2'd0)));
    RST = 1'b0;
    mon_en = 1'b1;
    push_seg(ST_OCIOSO, -1, -1, 2'd0);
    repeat (2) step();

    // Full brew, TIPO=2: dispense 3+2*2 TICKs.
    push_seg(ST_VERIFICA, 1, -1, 2'd0);
    push_seg(ST_AQUECE, -1, 4, 2'd0);
    push_seg(ST_MOE, -1, 2, 2'd0);
    push_seg(ST_DISPENSA, -1, 7, 2'd0);
    push_seg(ST_FIM, 1, -1, 2'd0);
    push_seg(ST_OCIOSO, -1, -1, 2'd0);
    start_brew(2'd2);
    check_eq("s1_verifica", 32'(ETAPA), 32'd1);
    TIPO = 2'd0;
    wait_etapa(ST_FIM, "s1_fim");
    check_eq("s1_concluido", 32'(CONCLUIDO), 32'd1);
    step();
    check_eq("s1_idle", 32'(ETAPA), 32'd0);
    check_eq("s1_concluido_off", 32'(CONCLUIDO), 32'd0);
    repeat (3) step();

    // Sensor check failures with priority copo > agua > cafe.
    for (int i = 0; i < 4; i++) begin
      SENSOR_COPO = vtab[i].copo; SENSOR_AGUA = vtab[i].agua; SENSOR_CAFE = vtab[i].cafe;
      push_seg(ST_VERIFICA, 1, -1, 2'd0);
      push_seg(ST_ERRO, -1, -1, vtab[i].cod);
      push_seg(ST_OCIOSO, -1, -1, 2'd0);
      start_brew(2'd1);
      check_eq($sformatf("s2_%0d_erro_early", i), 32'(ERRO), 32'd0);
      step();
      check_eq($sformatf("s2_%0d_erro", i), 32'(ERRO), 32'd1);
      check_eq($sformatf("s2_%0d_cod", i), 32'(COD_ERRO), 32'(vtab[i].cod));
      repeat (3) step();
      check_eq($sformatf("s2_%0d_cod_hold", i), 32'(COD_ERRO), 32'(vtab[i].cod));
      ack_erro();
      check_eq($sformatf("s2_%0d_ack_cod", i), 32'(COD_ERRO), 32'd0);
      repeat (3) step();
      check_eq($sformatf("s2_%0d_no_restart", i), 32'(ETAPA), 32'd0);
      SENSOR_COPO = 1'b1; SENSOR_AGUA = 1'b1; SENSOR_CAFE = 1'b1;
    end

    // Water lost on the TICK that would end dispense (TIPO=0): the fault wins.
    push_seg(ST_VERIFICA, 1, -1, 2'd0);
    push_seg(ST_AQUECE, -1, 4, 2'd0);
    push_seg(ST_MOE, -1, 2, 2'd0);
    push_seg(ST_DISPENSA, -1, 3, 2'd0);
    push_seg(ST_ERRO, -1, -1, 2'd2);
    push_seg(ST_OCIOSO, -1, -1, 2'd0);
    start_brew(2'd0);
    n = 0; k = 0;
    while ((n < 3) && (k < 300)) begin
      step();
      k++;
      if ((ETAPA == 3'd4) && TICK) n++;
    end
    check_eq("s3_tick3_seen", n, 3);
    SENSOR_AGUA = 1'b0;
    step();
    check_eq("s3_dispensar_off", 32'(DISPENSAR), 32'd0);
    check_eq("s3_cod", 32'(COD_ERRO), 32'd2);
    SENSOR_AGUA = 1'b1;
    repeat (2) step();
    ack_erro();
    check_eq("s3_ack_etapa", 32'(ETAPA), 32'd0);
    check_eq("s3_ack_erro", 32'(ERRO), 32'd0);
    repeat (2) step();

    // Water is not monitored while grinding.
    push_seg(ST_VERIFICA, 1, -1, 2'd0);
    push_seg(ST_AQUECE, -1, 4, 2'd0);
    push_seg(ST_MOE, -1, 2, 2'd0);
    push_seg(ST_DISPENSA, -1, 5, 2'd0);
    push_seg(ST_FIM, 1, -1, 2'd0);
    push_seg(ST_OCIOSO, -1, -1, 2'd0);
    start_brew(2'd1);
    wait_etapa(ST_MOE, "s7_moe");
    SENSOR_AGUA = 1'b0;
    wait_etapa(ST_DISPENSA, "s7_disp");
    SENSOR_AGUA = 1'b1;
    wait_etapa(ST_OCIOSO, "s7_idle");
    repeat (2) step();

    // Cup and water both lost while heating: cup code wins.
    push_seg(ST_VERIFICA, 1, -1, 2'd0);
    push_seg(ST_AQUECE, -1, -1, 2'd0);
    push_seg(ST_ERRO, -1, -1, 2'd1);
    push_seg(ST_OCIOSO, -1, -1, 2'd0);
    start_brew(2'd2);
    wait_etapa(ST_AQUECE, "s8_aquece");
    step();
    SENSOR_COPO = 1'b0; SENSOR_AGUA = 1'b0;
    step();
    check_eq("s8_cod", 32'(COD_ERRO), 32'd1);
    check_eq("s8_aquecer_off", 32'(AQUECER), 32'd0);
    SENSOR_COPO = 1'b1; SENSOR_AGUA = 1'b1;
    ack_erro();
    repeat (2) step();

    // Asynchronous reset while grinding.
    push_seg(ST_VERIFICA, 1, -1, 2'd0);
    push_seg(ST_AQUECE, -1, 4, 2'd0);
    push_seg(ST_MOE, -1, -1, 2'd0);
    push_seg(ST_OCIOSO, -1, -1, 2'd0);
    start_brew(2'd0);
    wait_etapa(ST_MOE, "s5_moe");
    step();
    check_eq("s5_pre_moer", 32'(MOER), 32'd1);
    #2 RST = 1'b1;
    #1;
    check_eq("s5_moer", 32'(MOER), 32'd0);
    check_eq("s5_ocupado", 32'(OCUPADO), 32'd0);
    check_eq("s5_etapa", 32'(ETAPA), 32'd0);
    step();
    step();
    RST = 1'b0;
    repeat (2) step();

    // INICIAR/TIPO during heating are ignored: dispense uses latched TIPO=1.
    push_seg(ST_VERIFICA, 1, -1, 2'd0);
    push_seg(ST_AQUECE, -1, 4, 2'd0);
    push_seg(ST_MOE, -1, 2, 2'd0);
    push_seg(ST_DISPENSA, -1, 5, 2'd0);
    push_seg(ST_FIM, 1, -1, 2'd0);
    push_seg(ST_OCIOSO, -1, -1, 2'd0);
    start_brew(2'd1);
    TIPO = 2'd3;
    wait_etapa(ST_AQUECE, "s4_aquece");
    INICIAR = 1'b1;
    step();
    INICIAR = 1'b0;
    check_eq("s4_still_aquece", 32'(ETAPA), 32'd2);
    wait_etapa(ST_OCIOSO, "s4_idle");
    TIPO = 2'd0;
    repeat (2) step();

`ifdef SEQ_CANCELAR_EN
    // Abort on dispense TICK 1, together with a water fault: abort wins.
    push_seg(ST_VERIFICA, 1, -1, 2'd0);
    push_seg(ST_AQUECE, -1, 4, 2'd0);
    push_seg(ST_MOE, -1, 2, 2'd0);
    push_seg(ST_DISPENSA, -1, 1, 2'd0);
    push_seg(ST_OCIOSO, -1, -1, 2'd0);
    start_brew(2'd0);
    k = 0;
    while (!((ETAPA == 3'd4) && TICK) && (k < 300)) begin
      step();
      k++;
    end
    check_eq("s6_disp_tick1", 32'(ETAPA), 32'd4);
    CANCELAR = 1'b1; SENSOR_AGUA = 1'b0;
    step();
    CANCELAR = 1'b0; SENSOR_AGUA = 1'b1;
    check_eq("s6_etapa", 32'(ETAPA), 32'd0);
    check_eq("s6_concluido", 32'(CONCLUIDO), 32'd0);
    check_eq("s6_erro", 32'(ERRO), 32'd0);
    repeat (3) step();
`endif

    repeat (3) step();
    close_seg();
    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
